// File: rtl/memory_dumper.sv
// memory_dumper: walks a range of ternary data memory, converts each 9-trit
// balanced-ternary word to signed binary and streams it out over valid/ready.
`ifndef TRIT_NEG
`define TRIT_NEG 2'b10
`endif
`ifndef TRIT_ZERO
`define TRIT_ZERO 2'b00
`endif
`ifndef TRIT_POS
`define TRIT_POS 2'b01
`endif

module memory_dumper #(
    parameter int TRITS        = 9,
    parameter int VALUE_W      = 15,
    parameter int CNT_W        = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2*TRITS-1:0]        start_addr,
    input  logic [CNT_W-1:0]          word_count,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_read,
    output logic [2*TRITS-1:0]        mem_addr,
    input  logic [2*TRITS-1:0]        mem_read_data,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [2*TRITS-1:0]        dump_addr,
    output logic [2*TRITS-1:0]        dump_raw,
    output logic signed [VALUE_W-1:0] dump_value,
    output logic                      dump_invalid
);
    localparam int AW = 2 * TRITS;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CONVERT, S_OUTPUT, S_DONE
    } state_t;

    // Balanced-ternary +1; an illegal code is treated as TRIT_ZERO.
    function automatic logic [AW-1:0] bt_inc(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        logic          carry;
        r     = a;
        carry = 1'b1;
        for (int k = 0; k < TRITS; k++) begin
            if (carry) begin
                case (a[2*k +: 2])
                    `TRIT_NEG: begin r[2*k +: 2] = `TRIT_ZERO; carry = 1'b0; end
                    `TRIT_POS: begin r[2*k +: 2] = `TRIT_NEG;  carry = 1'b1; end
                    default:   begin r[2*k +: 2] = `TRIT_POS;  carry = 1'b0; end
                endcase
            end else begin
                r[2*k +: 2] = a[2*k +: 2];
            end
        end
        return r;
    endfunction

    function automatic logic signed [VALUE_W-1:0] trit_val(input logic [1:0] t);
        case (t)
            `TRIT_NEG: return {VALUE_W{1'b1}};
            `TRIT_POS: return {{(VALUE_W-1){1'b0}}, 1'b1};
            default:   return {VALUE_W{1'b0}};
        endcase
    endfunction

    function automatic logic word_invalid(input logic [AW-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < TRITS; k++) begin
            case (w[2*k +: 2])
                `TRIT_NEG, `TRIT_ZERO, `TRIT_POS: bad = bad;
                default:                          bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [AW-1:0]               raw_q, raw_d;
    logic signed [VALUE_W-1:0]   acc_q, acc_d;
    logic                        inv_q, inv_d;
    logic [2:0]                  wcnt_q, wcnt_d;
    logic [3:0]                  tcnt_q, tcnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        mem_read_q, mem_read_d;
    logic                        valid_q, valid_d;
    logic [3:0]                  tidx_s;
    logic [1:0]                  cur_trit_s;

    assign tidx_s     = 4'(TRITS - 1) - tcnt_q;
    assign cur_trit_s = raw_q[{tidx_s, 1'b0} +: 2];

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            raw_q      <= '0;
            acc_q      <= '0;
            inv_q      <= 1'b0;
            wcnt_q     <= 3'd0;
            tcnt_q     <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_read_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            raw_q      <= raw_d;
            acc_q      <= acc_d;
            inv_q      <= inv_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_read_q <= mem_read_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        raw_d   = raw_q;
        acc_d   = acc_q;
        inv_d   = inv_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && (word_count != '0)) begin
                    state_d = S_READ;
                    addr_d  = start_addr;
                    cnt_d   = word_count;
                end else if (start) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                wcnt_d  = 3'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == 3'(READ_LATENCY - 1)) begin
                    raw_d   = mem_read_data;
                    inv_d   = word_invalid(mem_read_data);
                    acc_d   = '0;
                    tcnt_d  = 4'd0;
                    state_d = S_CONVERT;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_CONVERT: begin
                // Horner step, most significant trit first.
                acc_d = acc_q + acc_q + acc_q + trit_val(cur_trit_s);
                if (tcnt_q == 4'(TRITS - 1)) begin
                    state_d = S_OUTPUT;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            S_OUTPUT: begin
                if (dump_ready) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    addr_d  = bt_inc(addr_q);
                    state_d = (cnt_q == CNT_ONE) ? S_DONE : S_READ;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the strobes are registered.
    always_comb begin
        busy_d     = (state_d == S_READ) || (state_d == S_WAIT) ||
                     (state_d == S_CONVERT) || (state_d == S_OUTPUT);
        done_d     = (state_d == S_DONE);
        mem_read_d = (state_d == S_READ);
        valid_d    = (state_d == S_OUTPUT);
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_read     = mem_read_q;
    assign mem_addr     = addr_q;
    assign dump_valid   = valid_q;
    assign dump_addr    = addr_q;
    assign dump_raw     = raw_q;
    assign dump_value   = acc_q;
    assign dump_invalid = inv_q;

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper: latency, conversion, address stepping,
// wrap, back-pressure, zero count, illegal trits and mid-dump reset.
module tb_memory_dumper;
    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [17:0]        start_addr = 18'h0;
    logic [9:0]         word_count = 10'd0;
    logic               busy, done, mem_read, dump_valid, dump_invalid;
    logic [17:0]        mem_addr, dump_addr, dump_raw;
    logic [17:0]        mem_read_data = 18'h0;
    logic               dump_ready = 1'b0;
    logic signed [14:0] dump_value;

    int checks = 0;
    int errors = 0;

    logic [17:0] mem [logic [17:0]];
    int          cyc = 0, rd_cnt = 0, rd_cyc = 0, v_cyc = 0, done_cnt = 0;
    logic [17:0] rd_addr = 18'h0;
    logic        busy_seen = 1'b0, prev_v = 1'b0;

    logic [17:0]        b_addr, b_raw;
    logic signed [14:0] b_val;
    logic               b_inv;
    int                 b_lat;

    memory_dumper dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy(busy), .done(done), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_raw(dump_raw), .dump_value(dump_value), .dump_invalid(dump_invalid)
    );

    always #5 clock = ~clock;

    // One-cycle-latency memory model.
    always @(posedge clock) begin
        if (mem_read) mem_read_data <= mem.exists(mem_addr) ? mem[mem_addr] : 18'h0;
    end

    // Event monitor sampled on the falling edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (mem_read) begin rd_cnt = rd_cnt + 1; rd_cyc = cyc; rd_addr = mem_addr; end
        if (done) done_cnt = done_cnt + 1;
        if (busy) busy_seen = 1'b1;
        if (dump_valid && !prev_v) v_cyc = cyc;
        prev_v = dump_valid;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [17:0] a, input logic [9:0] n);
        start_addr = a; word_count = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic get_beat(input int stall);
        int n;
        int rd0;
        n = 0;
        while (!dump_valid && n < 200) begin step(); n++; end
        if (!dump_valid) begin check_val("beat_timeout", 32'd0, 32'd1); return; end
        b_addr = dump_addr; b_raw = dump_raw; b_val = dump_value; b_inv = dump_invalid;
        b_lat  = v_cyc - rd_cyc;
        rd0    = rd_cnt;
        for (int i = 0; i < stall; i++) begin
            step();
            check_val("stall_valid", dump_valid, 1'b1);
            check_val("stall_value", int'(dump_value), int'(b_val));
            check_val("stall_raw", dump_raw, b_raw);
            check_val("stall_addr", dump_addr, b_addr);
            check_val("stall_inv", dump_invalid, b_inv);
        end
        if (stall > 0) check_val("stall_no_read", rd_cnt, rd0);
        dump_ready = 1'b1;
        step();
        dump_ready = 1'b0;
        check_val("valid_drop", dump_valid, 1'b0);
    endtask

    initial begin
        int r0, d0, n;
        mem[18'h00010] = 18'h00001;
        mem[18'h00000] = 18'h15555;
        mem[18'h00001] = 18'h2AAAA;
        mem[18'h00006] = 18'h00006;
        mem[18'h15555] = 18'h00006;
        mem[18'h2AAAA] = 18'h00001;
        mem[18'h00020] = 18'h00007;

        step(); step(); step();
        check_val("rst_ctrl", {busy, done, mem_read, dump_valid, dump_invalid}, 5'd0);
        check_val("rst_addr", mem_addr, 18'h0);
        check_val("rst_value", int'(dump_value), 32'd0);
        reset = 1'b1;
        step();

        // single word, value +1, latency
        pulse_start(18'h00010, 10'd1);
        check_val("t1_busy", busy, 1'b1);
        get_beat(0);
        check_val("t1_addr", b_addr, 18'h00010);
        check_val("t1_value", int'(b_val), 32'd1);
        check_val("t1_inv", b_inv, 1'b0);
        check_val("t1_latency", b_lat, 32'd11);
        check_val("t1_done", done, 1'b1);
        check_val("t1_busy_end", busy, 1'b0);
        step();
        check_val("t1_done_pulse", done, 1'b0);

        // three words, extremes and small value
        pulse_start(18'h00000, 10'd3);
        get_beat(0);
        check_val("t2_addr0", b_addr, 18'h00000);
        check_val("t2_val0", int'(b_val), 32'd9841);
        get_beat(0);
        check_val("t2_addr1", b_addr, 18'h00001);
        check_val("t2_val1", int'(b_val), -32'sd9841);
        get_beat(0);
        check_val("t2_addr2", b_addr, 18'h00006);
        check_val("t2_val2", int'(b_val), 32'd2);
        check_val("t2_done", done, 1'b1);
        step();

        // address wrap
        pulse_start(18'h15555, 10'd2);
        get_beat(0);
        check_val("t3_addr0", b_addr, 18'h15555);
        check_val("t3_val0", int'(b_val), 32'd2);
        get_beat(0);
        check_val("t3_addr1", b_addr, 18'h2AAAA);
        check_val("t3_rd_addr1", rd_addr, 18'h2AAAA);
        check_val("t3_val1", int'(b_val), 32'd1);
        step();

        // back-pressure on the first beat
        r0 = rd_cnt;
        pulse_start(18'h00001, 10'd2);
        get_beat(5);
        check_val("t4_val0", int'(b_val), -32'sd9841);
        check_val("t4_addr0", b_addr, 18'h00001);
        get_beat(0);
        check_val("t4_val1", int'(b_val), 32'd2);
        check_val("t4_addr1", b_addr, 18'h00006);
        check_val("t4_reads", rd_cnt - r0, 32'd2);
        step();

        // zero count
        r0 = rd_cnt;
        busy_seen = 1'b0;
        pulse_start(18'h00000, 10'd0);
        check_val("t5_done", done, 1'b1);
        step();
        check_val("t5_done_pulse", done, 1'b0);
        step();
        check_val("t5_busy_never", busy_seen, 1'b0);
        check_val("t5_no_read", rd_cnt, r0);

        // illegal trit code
        pulse_start(18'h00020, 10'd1);
        get_beat(0);
        check_val("t6_raw", b_raw, 18'h00007);
        check_val("t6_value", int'(b_val), 32'd3);
        check_val("t6_inv", b_inv, 1'b1);
        step();

        // reset during CONVERT, then restart
        r0 = rd_cnt;
        pulse_start(18'h00010, 10'd1);
        n = 0;
        while (rd_cnt == r0 && n < 50) begin step(); n++; end
        check_val("t7_read_seen", rd_cnt, r0 + 1);
        step(); step(); step(); step();
        d0 = done_cnt;
        r0 = rd_cnt;
        reset = 1'b0;
        #1;
        check_val("t7_rst_ctrl", {busy, done, mem_read, dump_valid, dump_invalid}, 5'd0);
        check_val("t7_rst_addr", dump_addr, 18'h0);
        check_val("t7_rst_raw", dump_raw, 18'h0);
        check_val("t7_rst_value", int'(dump_value), 32'd0);
        step(); step(); step();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check_val("t7_no_done", done_cnt, d0);
        check_val("t7_no_read", rd_cnt, r0);
        pulse_start(18'h00010, 10'd1);
        get_beat(0);
        check_val("t7_value", int'(b_val), 32'd1);
        check_val("t7_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
